// File: rtl/mips_pkg.sv
// Types and constants shared across the MIPS pipeline.
// The control bundle's bit order matches the main decoder output.
package mips_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic {RUN, BUBBLE} stageState_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detect: the instruction in ID reads the register a load in EX
// is about to produce. A load to $0 never creates a dependency.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              valid_e,
  input  logic              mem_to_reg_e,
  input  logic [REG_AW-1:0] rt_e,
  output logic              hz
);

  assign hz = valid_d & valid_e & mem_to_reg_e & (rt_e != '0) &
              ((rs_d == rt_e) | (rt_d == rt_e));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and perf event counters.
//   state  | meaning
//   RUN    | last edge captured the ID instruction (or reset)
//   BUBBLE | last edge inserted a bubble (stall or flush)
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic              reg_write_d,
  input  logic              reg_dst_d,
  input  logic              alu_src_d,
  input  logic              branch_d,
  input  logic              mem_write_d,
  input  logic              mem_to_reg_d,
  input  logic [1:0]        alu_op_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [DATA_W-1:0] sign_imm_d,
  input  logic [DATA_W-1:0] pc_plus4_d,
  input  logic              flush_e,
  output logic              stall_d,
  output logic              reg_write_e,
  output logic              reg_dst_e,
  output logic              alu_src_e,
  output logic              branch_e,
  output logic              mem_write_e,
  output logic              mem_to_reg_e,
  output logic [1:0]        alu_op_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] sign_imm_e,
  output logic [DATA_W-1:0] pc_plus4_e,
  output logic [REG_AW-1:0] rs_e,
  output logic [REG_AW-1:0] rt_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              valid_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t       ctrlD;
  ctrl_t       ctrlE;
  stageState_t state;
  logic        hz;

  assign ctrlD = {reg_write_d, reg_dst_d, alu_src_d, branch_d,
                  mem_write_d, mem_to_reg_d, alu_op_d};

  assign reg_write_e  = ctrlE.reg_write;
  assign reg_dst_e    = ctrlE.reg_dst;
  assign alu_src_e    = ctrlE.alu_src;
  assign branch_e     = ctrlE.branch;
  assign mem_write_e  = ctrlE.mem_write;
  assign mem_to_reg_e = ctrlE.mem_to_reg;
  assign alu_op_e     = ctrlE.alu_op;

  hazard_unit #(.REG_AW(REG_AW)) uHazard (
    .valid_d      (valid_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .valid_e      (valid_e),
    .mem_to_reg_e (ctrlE.mem_to_reg),
    .rt_e         (rt_e),
    .hz           (hz)
  );

  // A flush squashes the ID instruction upstream, so holding it would be pointless.
  assign stall_d = hz & ~flush_e & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlE      <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      sign_imm_e <= '0;
      pc_plus4_e <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      state      <= RUN;
    end else if (flush_e || hz) begin
      // Data cleared too so a bubble carries no stale values downstream.
      ctrlE      <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      sign_imm_e <= '0;
      pc_plus4_e <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      state      <= BUBBLE;
      if (flush_e) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      ctrlE      <= ctrlD;
      valid_e    <= valid_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      sign_imm_e <= sign_imm_d;
      pc_plus4_e <= pc_plus4_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
      state      <= RUN;
    end
  end

  // With a bubble in EX valid_e is low, so a hazard there means the bubble leaked.
  assert property (@(posedge clk) disable iff (reset) !(state == BUBBLE && hz));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes the expected EX slot into a
// queue, a monitor pops and compares one entry after every clock edge.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  localparam logic [7:0] C_RT = 8'b1100_0010;
  localparam logic [7:0] C_LW = 8'b1010_0100;
  localparam logic [7:0] C_SW = 8'b0010_1000;

  typedef struct packed {
    logic          valid;
    logic [7:0]    ctrl;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } din_t;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic          valid;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_e = 1'b0;
  din_t dIn = '0;

  logic          stall_d;
  logic          reg_write_e, reg_dst_e, alu_src_e, branch_e;
  logic          mem_write_e, mem_to_reg_e, valid_e;
  logic [1:0]    alu_op_e;
  logic [DW-1:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e;
  logic [AW-1:0] rs_e, rt_e, rd_e;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int passCnt = 0;
  int totalCnt = 0;
  snap_t expQ[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_d      (dIn.valid),
    .reg_write_d  (dIn.ctrl[7]),
    .reg_dst_d    (dIn.ctrl[6]),
    .alu_src_d    (dIn.ctrl[5]),
    .branch_d     (dIn.ctrl[4]),
    .mem_write_d  (dIn.ctrl[3]),
    .mem_to_reg_d (dIn.ctrl[2]),
    .alu_op_d     (dIn.ctrl[1:0]),
    .rd1_d        (dIn.rd1),
    .rd2_d        (dIn.rd2),
    .rs_d         (dIn.rs),
    .rt_d         (dIn.rt),
    .rd_d         (dIn.rd),
    .sign_imm_d   (dIn.imm),
    .pc_plus4_d   (dIn.pc4),
    .flush_e      (flush_e),
    .stall_d      (stall_d),
    .reg_write_e  (reg_write_e),
    .reg_dst_e    (reg_dst_e),
    .alu_src_e    (alu_src_e),
    .branch_e     (branch_e),
    .mem_write_e  (mem_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .alu_op_e     (alu_op_e),
    .rd1_e        (rd1_e),
    .rd2_e        (rd2_e),
    .sign_imm_e   (sign_imm_e),
    .pc_plus4_e   (pc_plus4_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .rd_e         (rd_e),
    .valid_e      (valid_e),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  snap_t act;
  assign act = {reg_write_e, reg_dst_e, alu_src_e, branch_e, mem_write_e,
                mem_to_reg_e, alu_op_e, valid_e, rd1_e, rd2_e, sign_imm_e,
                pc_plus4_e, rs_e, rt_e, rd_e, stall_cnt, flush_cnt};

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    totalCnt++;
    if (got === want) passCnt++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  function automatic din_t mkIn(input logic v, input logic [7:0] c, input int rs,
                                input int rt, input int rd, input int pc);
    din_t d;
    d.valid = v;
    d.ctrl  = c;
    d.rs    = AW'(rs);
    d.rt    = AW'(rt);
    d.rd    = AW'(rd);
    d.pc4   = DW'(pc);
    d.rd1   = 32'hA000_0000 + DW'(pc);
    d.rd2   = 32'hB000_0000 + DW'(pc);
    d.imm   = 32'hFFFF_0000 | DW'(pc);
    return d;
  endfunction

  function automatic snap_t take(input din_t d, input int sc, input int fc);
    snap_t s;
    s.ctrl = d.ctrl; s.valid = d.valid;
    s.rd1 = d.rd1; s.rd2 = d.rd2; s.imm = d.imm; s.pc4 = d.pc4;
    s.rs = d.rs; s.rt = d.rt; s.rd = d.rd;
    s.sc = CW'(sc); s.fc = CW'(fc);
    return s;
  endfunction

  function automatic snap_t bubble(input int sc, input int fc);
    snap_t s;
    s = '0;
    s.sc = CW'(sc); s.fc = CW'(fc);
    return s;
  endfunction

  task automatic step(input din_t d, input logic fl, input logic rst,
                      input logic expStall, input snap_t e);
    @(negedge clk);
    dIn = d;
    flush_e = fl;
    reset = rst;
    #1;
    chk("stall_d", {159'b0, stall_d}, {159'b0, expStall});
    expQ.push_back(e);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        snap_t e;
        e = expQ.pop_front();
        chk("ex_slot", act, e);
      end
    end
  end

  initial begin : stim
    din_t d;
    din_t nop;
    nop = '0;

    step(nop, 1'b0, 1'b1, 1'b0, bubble(0, 0));
    step(nop, 1'b0, 1'b1, 1'b0, bubble(0, 0));

    d = mkIn(1, C_RT, 1, 2, 3, 'h04);           // add $3,$1,$2
    step(d, 1'b0, 1'b0, 1'b0, take(d, 0, 0));
    d = mkIn(1, C_LW, 1, 5, 0, 'h08);           // lw $5,0($1)
    step(d, 1'b0, 1'b0, 1'b0, take(d, 0, 0));
    d = mkIn(1, C_RT, 5, 2, 6, 'h0c);           // add $6,$5,$2: load-use
    step(d, 1'b0, 1'b0, 1'b1, bubble(1, 0));
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 0));
    d = mkIn(1, C_LW, 1, 0, 0, 'h10);           // lw $0,0($1)
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 0));
    d = mkIn(1, C_RT, 0, 2, 6, 'h14);           // add $6,$0,$2: no hazard on $0
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 0));
    d = mkIn(1, C_LW, 1, 5, 0, 'h18);
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 0));
    d = mkIn(1, C_RT, 5, 2, 6, 'h1c);           // hazard + flush: flush wins
    step(d, 1'b1, 1'b0, 1'b0, bubble(1, 1));
    d = mkIn(1, C_LW, 1, 7, 0, 'h20);           // lw $7
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 1));
    d = mkIn(0, C_RT, 7, 7, 4, 'h24);           // invalid ID never stalls
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 1));
    d = mkIn(1, C_LW, 9, 8, 0, 'h28);           // lw $8,0($9)
    step(d, 1'b0, 1'b0, 1'b0, take(d, 1, 1));
    d = mkIn(1, C_LW, 8, 10, 0, 'h2c);          // lw $10,0($8): back-to-back
    step(d, 1'b0, 1'b0, 1'b1, bubble(2, 1));
    step(d, 1'b0, 1'b0, 1'b0, take(d, 2, 1));
    d = mkIn(1, C_RT, 10, 10, 11, 'h30);        // add $11,$10,$10
    step(d, 1'b0, 1'b0, 1'b1, bubble(3, 1));
    step(d, 1'b0, 1'b0, 1'b0, take(d, 3, 1));
    d = mkIn(1, C_LW, 1, 12, 0, 'h34);          // lw $12
    step(d, 1'b0, 1'b0, 1'b0, take(d, 3, 1));
    d = mkIn(1, C_SW, 1, 12, 0, 'h38);          // sw $12: match on rt_d
    step(d, 1'b0, 1'b0, 1'b1, bubble(4, 1));
    step(d, 1'b0, 1'b0, 1'b0, take(d, 4, 1));

    // drive stall_cnt (4 bits) into saturation at 15 and one past it
    for (int k = 0; k < 12; k++) begin
      int s;
      s = (5 + k > 15) ? 15 : 5 + k;
      d = mkIn(1, C_LW, 1, 5, 0, 'h100 + 16 * k);
      step(d, 1'b0, 1'b0, 1'b0, take(d, s - ((5 + k > 15) ? 0 : 1), 1));
      d = mkIn(1, C_RT, 5, 2, 6, 'h104 + 16 * k);
      step(d, 1'b0, 1'b0, 1'b1, bubble(s, 1));
      step(d, 1'b0, 1'b0, 1'b0, take(d, s, 1));
    end

    d = mkIn(1, C_LW, 1, 5, 0, 'h200);
    step(d, 1'b0, 1'b0, 1'b0, take(d, 15, 1));
    d = mkIn(1, C_RT, 5, 2, 6, 'h204);          // reset during the stall cycle
    step(d, 1'b0, 1'b1, 1'b0, bubble(0, 0));
    step(d, 1'b0, 1'b0, 1'b0, take(d, 0, 0));

    @(negedge clk);
    dIn = '0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 160'(expQ.size()), 160'(0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
